// File: rtl/fsm_ctrl_param.sv
// Flow-control supervisor for NUM_FIFOS FIFOs: loads thresholds in INIT, tracks idle/active, latches errors.
// Optional macro IDLE_WAIT_EN: ACTIVE->IDLE needs IDLE_WAIT consecutive all-empty cycles.
module fsm_ctrl_param #(
    parameter int NUM_FIFOS = 5,
    parameter int THR_W     = 5,
    parameter int IDLE_WAIT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [NUM_FIFOS*THR_W-1:0] low_in,
    input  logic [NUM_FIFOS*THR_W-1:0] high_in,
    input  logic [NUM_FIFOS-1:0]       empties,
    input  logic [NUM_FIFOS-1:0]       errors,
    output logic [NUM_FIFOS*THR_W-1:0] low_out,
    output logic [NUM_FIFOS*THR_W-1:0] high_out,
    output logic [2:0]                 state,
    output logic                       idle_out,
    output logic                       active_out,
    output logic                       error_out,
    output logic [NUM_FIFOS-1:0]       err_src,
    output logic                       cfg_err
);

    localparam int TW = NUM_FIFOS * THR_W;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    // True when any channel's low threshold exceeds its high threshold (unsigned).
    function automatic logic cfg_bad(input logic [TW-1:0] lo, input logic [TW-1:0] hi);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (lo[i*THR_W +: THR_W] > hi[i*THR_W +: THR_W]) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [TW-1:0]        low_r;
    logic [TW-1:0]        high_r;
    logic [NUM_FIFOS-1:0] err_src_r;
    logic                 cfg_err_r;
    logic                 idle_r;
    logic                 active_r;
    logic                 error_r;
    logic                 any_err_s;
    logic                 all_empty_s;
    logic                 cfg_bad_s;
    logic                 idle_ok_s;
    logic                 set_cfg_err_s;

    assign any_err_s   = |errors;
    assign all_empty_s = &empties;
    assign cfg_bad_s   = cfg_bad(low_in, high_in);

`ifdef IDLE_WAIT_EN
    localparam int CNT_W = $clog2(IDLE_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_WAIT - 1);

    logic [CNT_W-1:0] idle_cnt_r;
    logic [CNT_W-1:0] idle_cnt_nxt_s;

    // Count consecutive all-empty cycles in ACTIVE; the last one releases to IDLE.
    always_comb begin
        idle_ok_s      = 1'b0;
        idle_cnt_nxt_s = '0;
        if (state_r == ST_ACTIVE && all_empty_s) begin
            if (idle_cnt_r >= CNT_LAST) begin
                idle_ok_s = 1'b1;
            end else begin
                idle_cnt_nxt_s = idle_cnt_r + CNT_ONE;
            end
        end else begin
            idle_cnt_nxt_s = '0;
        end
    end

    // Counter register; cleared whenever the FSM is not staying in ACTIVE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_r <= '0;
        end else if (state_nxt_s != ST_ACTIVE) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_nxt_s;
        end
    end
`else
    assign idle_ok_s = all_empty_s;
`endif

    // Next-state decode; priority is errors, then init, then empties.
    always_comb begin
        state_nxt_s   = state_r;
        set_cfg_err_s = 1'b0;
        case (state_r)
            ST_RESET: begin
                state_nxt_s = ST_INIT;
            end
            ST_INIT: begin
                if (any_err_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (init) begin
                    state_nxt_s = ST_INIT;
                end else if (cfg_bad_s) begin
                    state_nxt_s   = ST_ERROR;
                    set_cfg_err_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (any_err_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (init) begin
                    state_nxt_s = ST_INIT;
                end else if (!all_empty_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (any_err_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (init) begin
                    state_nxt_s = ST_INIT;
                end else if (idle_ok_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                state_nxt_s = ST_ERROR;
            end
            // An illegal encoding is treated as a fault and parked in ERROR.
            default: begin
                state_nxt_s = ST_ERROR;
            end
        endcase
    end

    // State and decoded status flags, all registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RESET;
            idle_r   <= 1'b0;
            active_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            idle_r   <= (state_nxt_s == ST_IDLE);
            active_r <= (state_nxt_s == ST_ACTIVE);
            error_r  <= (state_nxt_s == ST_ERROR);
        end
    end

    // Thresholds track the inputs only while in INIT, including the exit edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_r  <= '0;
            high_r <= '0;
        end else if (state_r == ST_INIT) begin
            low_r  <= low_in;
            high_r <= high_in;
        end else begin
            low_r  <= low_r;
            high_r <= high_r;
        end
    end

    // Sticky error bookkeeping: error sources accumulate on entry to and while in ERROR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_src_r <= '0;
            cfg_err_r <= 1'b0;
        end else begin
            if (state_nxt_s == ST_ERROR) begin
                err_src_r <= err_src_r | errors;
            end else begin
                err_src_r <= err_src_r;
            end
            cfg_err_r <= cfg_err_r | set_cfg_err_s;
        end
    end

    assign state      = state_r;
    assign low_out    = low_r;
    assign high_out   = high_r;
    assign idle_out   = idle_r;
    assign active_out = active_r;
    assign error_out  = error_r;
    assign err_src    = err_src_r;
    assign cfg_err    = cfg_err_r;

endmodule
